// File: rtl/pc_return_stack.sv
// Call/return sequencer for the program counter: keeps a LIFO of return
// addresses and drives the PC load/increment/reset controls from registers.
module pc_return_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_out,
  input  logic             call,
  input  logic [WIDTH-1:0] call_target,
  input  logic             ret,
  input  logic             hold,
  output logic [WIDTH-1:0] pc_in,
  output logic             pc_load,
  output logic             pc_inc,
  output logic             pc_reset,
  output logic [CW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [DEPTH-1:0][WIDTH-1:0] stack;
  logic [AW-1:0]               push_idx, top_idx;
  logic [WIDTH-1:0]            ret_addr;
  logic                        both, do_push, do_replace, do_pop;

  assign empty    = (level == '0);
  assign full     = (level == CW'(DEPTH));
  assign ret_addr = pc_out + WIDTH'(1);

  // level < DEPTH whenever a push happens, so its low bits address the free slot
  assign push_idx = level[AW-1:0];
  assign top_idx  = push_idx - ONE_A;

  // call+ret on an empty stack degrades to a plain push
  assign both       = call & ret;
  assign do_replace = both & ~empty;
  assign do_push    = (both & empty) | (call & ~ret & ~full);
  assign do_pop     = ret & ~call & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      if (do_push)
        stack[push_idx] <= ret_addr;
      else if (do_replace)
        stack[top_idx] <= ret_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      level     <= '0;
      pc_in     <= '0;
      pc_load   <= 1'b0;
      pc_inc    <= 1'b0;
      pc_reset  <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pc_reset <= 1'b0;
      if (both) begin
        if (empty) level <= ONE_C;
        pc_in   <= call_target;
        pc_load <= 1'b1;
        pc_inc  <= 1'b0;
      end else if (call && !full) begin
        level   <= level + ONE_C;
        pc_in   <= call_target;
        pc_load <= 1'b1;
        pc_inc  <= 1'b0;
      end else if (call) begin
        overflow <= 1'b1;
        pc_load  <= 1'b0;
        pc_inc   <= ~hold;
      end else if (do_pop) begin
        level   <= level - ONE_C;
        pc_in   <= stack[top_idx];
        pc_load <= 1'b1;
        pc_inc  <= 1'b0;
      end else if (ret) begin
        underflow <= 1'b1;
        pc_load   <= 1'b0;
        pc_inc    <= ~hold;
      end else begin
        pc_load <= 1'b0;
        pc_inc  <= ~hold;
      end
    end
  end
endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: reset, call/return, nesting to full,
// overflow/underflow stickiness, simultaneous call+ret with wrap, and hold.
module tb_pc_return_stack;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset, call, ret, hold;
  logic [WIDTH-1:0] pc_out, call_target, pc_in;
  logic             pc_load, pc_inc, pc_reset, empty, full, overflow, underflow;
  logic [CW-1:0]    level;
  int               errors = 0;
  int               checks = 0;

  pc_return_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .call(call),
    .call_target(call_target), .ret(ret), .hold(hold), .pc_in(pc_in),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_reset(pc_reset), .level(level),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; call = 1'b1; ret = 1'b0; hold = 1'b0;
    pc_out = '0; call_target = 16'd5;
    step; step;
    chk("rst_pc_reset", pc_reset, 1);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pc_in", pc_in, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    reset = 1'b1; call = 1'b0;
    step;
    chk("post_rst_pc_reset", pc_reset, 0);
    chk("post_rst_pc_inc", pc_inc, 1);
    chk("post_rst_pc_load", pc_load, 0);

    // call / return pair
    pc_out = 16'd100; call_target = 16'd500; call = 1'b1;
    step;
    chk("call_load", pc_load, 1);
    chk("call_pc_in", pc_in, 500);
    chk("call_level", level, 1);
    chk("call_inc", pc_inc, 0);
    chk("call_empty", empty, 0);
    call = 1'b0;
    step;
    chk("idle_load", pc_load, 0);
    chk("idle_inc", pc_inc, 1);
    chk("idle_pc_in_hold", pc_in, 500);
    pc_out = 16'd503; ret = 1'b1;
    step;
    chk("ret_pc_in", pc_in, 101);
    chk("ret_load", pc_load, 1);
    chk("ret_level", level, 0);
    chk("ret_empty", empty, 1);
    ret = 1'b0;

    // nest to full
    for (int i = 1; i <= 8; i++) begin
      pc_out = WIDTH'(10*i); call_target = WIDTH'(1000+i); call = 1'b1;
      step;
      chk("nest_level", level, i);
      chk("nest_pc_in", pc_in, 1000+i);
    end
    chk("nest_full", full, 1);
    chk("nest_empty", empty, 0);
    pc_out = 16'd90; call_target = 16'd2000;
    step;
    chk("ovf_flag", overflow, 1);
    chk("ovf_load", pc_load, 0);
    chk("ovf_inc", pc_inc, 1);
    chk("ovf_level", level, 8);
    chk("ovf_full", full, 1);
    call = 1'b0; ret = 1'b1;
    for (int i = 8; i >= 1; i--) begin
      step;
      chk("unwind_pc_in", pc_in, 10*i+1);
      chk("unwind_level", level, i-1);
      chk("unwind_load", pc_load, 1);
    end
    chk("unwind_empty", empty, 1);
    chk("unwind_ovf_sticky", overflow, 1);

    // underflow
    step;
    chk("unf_flag", underflow, 1);
    chk("unf_inc", pc_inc, 1);
    chk("unf_load", pc_load, 0);
    chk("unf_level", level, 0);
    chk("unf_pc_in_hold", pc_in, 11);
    ret = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("unf_sticky", underflow, 1);
    end
    reset = 1'b0;
    step;
    chk("clr_unf", underflow, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_pc_reset", pc_reset, 1);
    reset = 1'b1;
    step;

    // simultaneous call+ret with pc_out wrap
    pc_out = 16'd40; call_target = 16'd300; call = 1'b1;
    step;
    chk("sim_pre_level", level, 1);
    pc_out = 16'hFFFF; call_target = 16'd7; ret = 1'b1;
    step;
    chk("sim_pc_in", pc_in, 7);
    chk("sim_level", level, 1);
    chk("sim_load", pc_load, 1);
    chk("sim_inc", pc_inc, 0);
    call = 1'b0;
    step;
    chk("wrap_pc_in", pc_in, 0);
    chk("wrap_level", level, 0);
    chk("wrap_load", pc_load, 1);
    pc_out = 16'd200; call_target = 16'd9; call = 1'b1; ret = 1'b1;
    step;
    chk("sim_empty_level", level, 1);
    chk("sim_empty_pc_in", pc_in, 9);
    chk("sim_empty_unf", underflow, 0);
    call = 1'b0;
    step;
    chk("sim_empty_ret", pc_in, 201);
    ret = 1'b0;

    // hold
    hold = 1'b1;
    step;
    chk("hold_inc", pc_inc, 0);
    chk("hold_load", pc_load, 0);
    pc_out = 16'd50; call_target = 16'd60; call = 1'b1;
    step;
    chk("hold_call_load", pc_load, 1);
    chk("hold_call_pc_in", pc_in, 60);
    chk("hold_call_level", level, 1);
    call = 1'b0;
    step;
    chk("hold_idle_inc", pc_inc, 0);
    hold = 1'b0;
    step;
    chk("unhold_inc", pc_inc, 1);

    // reset discards an in-flight call
    reset = 1'b0; call = 1'b1; pc_out = 16'd70; call_target = 16'd80;
    step;
    chk("rst_mid_load", pc_load, 0);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_pc_in", pc_in, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Call/return sequencer that sits on the control side of the program counter.
- Consumes the PC's current value and drives the PC's in/load/inc/reset controls.
- Holds a LIFO of return addresses: a call pushes pc_out+1 and jumps to a target; a return pops the stack and jumps to the popped address.
- Gives the CPU subroutine support without software-managed return addresses.

Parameters:
WIDTH, 16, address width; matches PC word width.
DEPTH, 8, number of return-address entries (power of two, >=2).
CW, $clog2(DEPTH+1), derived width of the level output.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
pc_out  in  WIDTH  current PC value.
call  in  1  request: push pc_out+1, jump to call_target.
call_target  in  WIDTH  jump destination for call.
ret  in  1  request: pop stack, jump to popped address.
hold  in  1  stall: PC keeps its value this step.
pc_in  out  WIDTH  load value to PC.
pc_load  out  1  PC load strobe.
pc_inc  out  1  PC increment strobe.
pc_reset  out  1  PC reset strobe.
level  out  CW  number of valid entries.
empty  out  1  level==0.
full  out  1  level==DEPTH.
overflow  out  1  sticky: call attempted while full.
underflow  out  1  sticky: ret attempted while empty.

Behaviour:
- All outputs registered; a request sampled at edge N is reflected on pc_* after edge N, so the PC acts on it at edge N+1.
- Reset (reset==0 at an edge):
  - level=0, pc_in=0, pc_load=0, pc_inc=0, pc_reset=1; overflow and underflow cleared; stack contents don't-care.
  - pc_reset clears at the first edge with reset==1.
  - Reset mid-operation discards any in-flight request.
- Priority per edge (reset==1), first match wins:
  1. call & ret:
     - If not empty: replace top entry with pc_out+1 (level unchanged).
     - If empty: behave as a plain call (push, level becomes 1). underflow is not set.
     - In both cases: pc_in=call_target, pc_load=1, pc_inc=0.
  2. call & !full: push pc_out+1; level+1; pc_in=call_target, pc_load=1, pc_inc=0.
  3. call & full: no push; overflow<=1; pc_load=0; pc_inc=!hold.
  4. ret & !empty: pop; level-1; pc_in=popped entry, pc_load=1, pc_inc=0.
  5. ret & empty: no pop; underflow<=1; pc_load=0; pc_inc=!hold.
  6. none: pc_load=0; pc_inc=!hold; pc_in holds its previous value.
- hold suppresses only pc_inc. call/ret are still honoured while hold==1.
- Arithmetic: pc_out+1 is computed modulo 2^WIDTH, so 16'hFFFF pushes 16'h0000.
- Storage: stack pointer counts 0..DEPTH. Overflow/underflow never move the pointer or corrupt entries.
- pc_load and pc_inc are never both 1. pc_reset is 0 whenever reset==1 was sampled.
- empty and full are decoded from the registered level; at most one is 1.
- overflow and underflow clear only on reset.

Test Plan:
- Reset: hold reset=0 two edges with call=1 -> pc_reset=1, pc_load=0, pc_inc=0, level=0, empty=1; one edge after reset=1, pc_reset=0, pc_inc=1.
- Call/return pair: pc_out=100, call_target=500, call for 1 cycle -> pc_load=1, pc_in=500, level=1. Later pc_out=503, ret -> pc_in=101, pc_load=1, level=0.
- Nesting and full: 8 calls with pc_out=10,20..80 -> full=1. A 9th call -> overflow=1, pc_load=0, level=8. Then 8 rets return 81,71..11 in order.
- Underflow: ret while empty -> underflow=1, pc_inc=1, pc_load=0. underflow stays 1 through 5 idle cycles and clears only on reset.
- Simultaneous and wrap: stack top=41, pc_out=16'hFFFF, call=ret=1, call_target=7 -> pc_in=7, level unchanged, top becomes 0. A following ret -> pc_in=0.
- Hold: hold=1 idle -> pc_inc=0 and pc_load=0. hold=1 with call -> pc_load=1 (jump still taken).
